// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared constants for the SPI slave input front end.
//   CS_IDLE / SCLK_IDLE / MOSI_IDLE : level each pin rests at when no master
//                                     is talking (cs is active low).
//   DEF_BITS_PER_FRAME              : default number of sclk rising edges
//                                     that make up one frame.
//   BIT_CNT_W                       : bit counter width for the default frame.
// ---------------------------------------------------------------------------
package spi_pkg;

    localparam logic CS_IDLE   = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

    localparam int DEF_BITS_PER_FRAME = 8;
    localparam int BIT_CNT_W          = $clog2(DEF_BITS_PER_FRAME);

    typedef logic [BIT_CNT_W-1:0] bitCnt_t;

endpackage

// File: rtl/spi_input_frontend_input_channel.sv
// ---------------------------------------------------------------------------
// input_channel
// Conditions one raw asynchronous pin: two-flop synchronizer, glitch filter
// and registered edge pulses.
//   clk, reset   : system clock, synchronous active-high reset
//   i_pin        : raw asynchronous pin
//   o_cond       : synchronized and filtered level
//   o_pos_edge   : one-cycle pulse, registered with o_cond going 0->1
//   o_neg_edge   : one-cycle pulse, registered with o_cond going 1->0
//   o_rise_evt   : combinational, high in the cycle before o_pos_edge
//   o_fall_evt   : combinational, high in the cycle before o_neg_edge
// The *_evt strobes let the parent register its own state on the very same
// clock edge that o_cond and the edge pulses update.
// ---------------------------------------------------------------------------
module input_channel
    import spi_pkg::*;
#(
    parameter int   WAIT_CYCLES = 3,
    parameter logic IDLE_VAL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_cond,
    output logic o_pos_edge,
    output logic o_neg_edge,
    output logic o_rise_evt,
    output logic o_fall_evt
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYCLES);

    logic             r_meta;
    logic             r_sync;
    logic             r_cond;
    logic             r_pos;
    logic             r_neg;
    logic [CNT_W-1:0] r_cnt;
    logic             w_change;

    // The filtered level may only follow the synchronized level once the
    // mismatch has already survived WAIT_CYCLES earlier cycles; this is the
    // last mismatching cycle before the change is committed.
    assign w_change   = (r_sync != r_cond) && (r_cnt == WAIT_LAST);
    assign o_rise_evt = w_change & r_sync;
    assign o_fall_evt = w_change & ~r_sync;

    // Synchronizer, filter counter and conditioned level. Any cycle where the
    // synchronized value agrees with the conditioned one clears the count, so
    // an interrupted mismatch has to start over from zero. The counter is
    // cleared on a commit too, which keeps edge pulses at least two cycles
    // apart on a channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= IDLE_VAL;
            r_sync <= IDLE_VAL;
            r_cond <= IDLE_VAL;
            r_pos  <= 1'b0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_pos  <= o_rise_evt;
            r_neg  <= o_fall_evt;
            if (r_sync == r_cond) begin
                r_cnt <= '0;
            end else if (w_change) begin
                r_cond <= r_sync;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_cond     = r_cond;
    assign o_pos_edge = r_pos;
    assign o_neg_edge = r_neg;

endmodule

// File: rtl/spi_input_frontend.sv
// ---------------------------------------------------------------------------
// spi_input_frontend
// Upstream front end of the SPI slave: conditions sclk, cs and mosi and
// tracks the bit position inside the current frame.
//   clk, reset      : system clock, synchronous active-high reset
//   sclk_pin        : raw serial clock
//   cs_pin          : raw chip select, active low
//   mosi_pin        : raw master-out data
//   sclk_cond / cs_cond / mosi_cond : filtered levels
//   sclk_pos_edge / sclk_neg_edge   : one-cycle sclk edge pulses
//   cs_fall / cs_rise               : one-cycle frame start / end pulses
//   bit_cnt         : sclk rising edges in this frame, modulo BITS_PER_FRAME
//   byte_done       : pulse on the edge that completes a byte
//   frame_err       : pulse when cs deasserts part way through a byte
// ---------------------------------------------------------------------------
module spi_input_frontend
    import spi_pkg::*;
#(
    parameter int WAIT_CYCLES    = 3,
    parameter int BITS_PER_FRAME = DEF_BITS_PER_FRAME
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sclk_pin,
    input  logic                              cs_pin,
    input  logic                              mosi_pin,
    output logic                              sclk_cond,
    output logic                              cs_cond,
    output logic                              mosi_cond,
    output logic                              sclk_pos_edge,
    output logic                              sclk_neg_edge,
    output logic                              cs_fall,
    output logic                              cs_rise,
    output logic [$clog2(BITS_PER_FRAME)-1:0] bit_cnt,
    output logic                              byte_done,
    output logic                              frame_err
);

    localparam int CNT_W = $clog2(BITS_PER_FRAME);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_FRAME - 1);

    logic             w_sclk_rise_evt;
    logic             w_sclk_fall_evt;
    logic             w_cs_rise_evt;
    logic             w_cs_fall_evt;
    logic             w_mosi_rise_evt;
    logic             w_mosi_fall_evt;
    logic             w_mosi_pos;
    logic             w_mosi_neg;
    logic             w_unused_evt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic             r_byte_done;
    logic             r_frame_err;

    input_channel #(.WAIT_CYCLES(WAIT_CYCLES), .IDLE_VAL(SCLK_IDLE)) u_sclk (
        .clk        (clk),
        .reset      (reset),
        .i_pin      (sclk_pin),
        .o_cond     (sclk_cond),
        .o_pos_edge (sclk_pos_edge),
        .o_neg_edge (sclk_neg_edge),
        .o_rise_evt (w_sclk_rise_evt),
        .o_fall_evt (w_sclk_fall_evt)
    );

    input_channel #(.WAIT_CYCLES(WAIT_CYCLES), .IDLE_VAL(CS_IDLE)) u_cs (
        .clk        (clk),
        .reset      (reset),
        .i_pin      (cs_pin),
        .o_cond     (cs_cond),
        .o_pos_edge (cs_rise),
        .o_neg_edge (cs_fall),
        .o_rise_evt (w_cs_rise_evt),
        .o_fall_evt (w_cs_fall_evt)
    );

    input_channel #(.WAIT_CYCLES(WAIT_CYCLES), .IDLE_VAL(MOSI_IDLE)) u_mosi (
        .clk        (clk),
        .reset      (reset),
        .i_pin      (mosi_pin),
        .o_cond     (mosi_cond),
        .o_pos_edge (w_mosi_pos),
        .o_neg_edge (w_mosi_neg),
        .o_rise_evt (w_mosi_rise_evt),
        .o_fall_evt (w_mosi_fall_evt)
    );

    // mosi edges and the sclk falling strobe carry no frame meaning here.
    assign w_unused_evt = ^{w_sclk_fall_evt, w_mosi_rise_evt, w_mosi_fall_evt,
                            w_mosi_pos, w_mosi_neg};

    // Frame tracking is driven from the channel strobes so its outputs land
    // in the same cycle as the edge pulses. Priority: a frame end beats a
    // frame start beats an sclk edge, so an sclk edge coinciding with either
    // cs transition is never counted. cs_cond here is still the pre-update
    // level, i.e. whether the frame was already open before this edge.
    // The counter wraps on its own because the frame length is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt   <= '0;
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_cs_rise_evt) begin
                r_frame_err <= (r_bit_cnt != '0);
                r_bit_cnt   <= '0;
            end else if (w_cs_fall_evt) begin
                r_bit_cnt <= '0;
            end else if (w_sclk_rise_evt && !cs_cond) begin
                r_bit_cnt   <= r_bit_cnt + CNT_W'(1);
                r_byte_done <= (r_bit_cnt == LAST_BIT);
            end
        end
    end

    assign bit_cnt   = r_bit_cnt;
    assign byte_done = r_byte_done;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_input_frontend.sv
// ---------------------------------------------------------------------------
// tb_spi_input_frontend
// Directed bench for spi_input_frontend with a behavioural reference model
// that is compared against the DUT every cycle, plus literal expectations.
// ---------------------------------------------------------------------------
module tb_spi_input_frontend;

    localparam int WAIT = 3;
    localparam int BPF  = 8;

    logic       clk;
    logic       reset;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    logic       sclk_cond;
    logic       cs_cond;
    logic       mosi_cond;
    logic       sclk_pos_edge;
    logic       sclk_neg_edge;
    logic       cs_fall;
    logic       cs_rise;
    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    spi_input_frontend #(.WAIT_CYCLES(WAIT), .BITS_PER_FRAME(BPF)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk_pin      (sclk_pin),
        .cs_pin        (cs_pin),
        .mosi_pin      (mosi_pin),
        .sclk_cond     (sclk_cond),
        .cs_cond       (cs_cond),
        .mosi_cond     (mosi_cond),
        .sclk_pos_edge (sclk_pos_edge),
        .sclk_neg_edge (sclk_neg_edge),
        .cs_fall       (cs_fall),
        .cs_rise       (cs_rise),
        .bit_cnt       (bit_cnt),
        .byte_done     (byte_done),
        .frame_err     (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and reports it when the values differ.
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive all three pins at a falling edge, then let 'cycles' clocks pass.
    task automatic applyStimulus(input logic s, input logic c, input logic m, input int cycles);
        sclk_pin = s;
        cs_pin   = c;
        mosi_pin = m;
        repeat (cycles) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model. Channel index 0 = sclk, 1 = cs, 2 = mosi.
    // A pin sample reaches the filter two clocks later; the filtered level
    // follows only after WAIT+1 consecutive disagreeing cycles. The frame
    // side counts opened-frame sclk rises as a plain integer.
    // ------------------------------------------------------------------
    logic mPin   [3];
    logic mIdle  [3];
    logic mS1    [3];
    logic mS2    [3];
    logic mCond  [3];
    logic mPos   [3];
    logic mNeg   [3];
    int   mRun   [3];
    int   mEdges;
    logic mBd;
    logic mFe;
    logic mOldCs;
    bit   modelValid = 1'b0;

    initial begin
        mIdle[0] = 1'b0;
        mIdle[1] = 1'b1;
        mIdle[2] = 1'b0;
    end

    // Model advances on every rising clock edge from the pins seen there.
    always @(posedge clk) begin
        mPin[0] = sclk_pin;
        mPin[1] = cs_pin;
        mPin[2] = mosi_pin;
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) begin
                mS1[ch]   = mIdle[ch];
                mS2[ch]   = mIdle[ch];
                mCond[ch] = mIdle[ch];
                mPos[ch]  = 1'b0;
                mNeg[ch]  = 1'b0;
                mRun[ch]  = 0;
            end
            mEdges     = 0;
            mBd        = 1'b0;
            mFe        = 1'b0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            mOldCs = mCond[1];
            for (int ch = 0; ch < 3; ch++) begin
                mPos[ch] = 1'b0;
                mNeg[ch] = 1'b0;
                if (mS2[ch] != mCond[ch]) begin
                    mRun[ch] = mRun[ch] + 1;
                    if (mRun[ch] == WAIT + 1) begin
                        mCond[ch] = mS2[ch];
                        mPos[ch]  = mS2[ch];
                        mNeg[ch]  = !mS2[ch];
                        mRun[ch]  = 0;
                    end
                end else begin
                    mRun[ch] = 0;
                end
                mS2[ch] = mS1[ch];
                mS1[ch] = mPin[ch];
            end
            mBd = 1'b0;
            mFe = 1'b0;
            if (mPos[1]) begin
                mFe    = (mEdges % BPF) != 0;
                mEdges = 0;
            end else if (mNeg[1]) begin
                mEdges = 0;
            end else if (mPos[0] && !mOldCs) begin
                mEdges = mEdges + 1;
                mBd    = (mEdges % BPF) == 0;
            end
        end
    end

    // Pulse tallies used by the literal checks.
    int cntSclkPos   = 0;
    int cntSclkNeg   = 0;
    int cntCsFall    = 0;
    int cntCsRise    = 0;
    int cntByteDone  = 0;
    int cntFrameErr  = 0;
    int cntErrOnRise = 0;

    // Compare process: shortly after each rising edge, every output against
    // the model, and tally observed pulses.
    always @(posedge clk) begin
        #1;
        if (modelValid) begin
            checkOutput("sclk_cond",     int'(sclk_cond),     int'(mCond[0]));
            checkOutput("cs_cond",       int'(cs_cond),       int'(mCond[1]));
            checkOutput("mosi_cond",     int'(mosi_cond),     int'(mCond[2]));
            checkOutput("sclk_pos_edge", int'(sclk_pos_edge), int'(mPos[0]));
            checkOutput("sclk_neg_edge", int'(sclk_neg_edge), int'(mNeg[0]));
            checkOutput("cs_rise",       int'(cs_rise),       int'(mPos[1]));
            checkOutput("cs_fall",       int'(cs_fall),       int'(mNeg[1]));
            checkOutput("bit_cnt",       int'(bit_cnt),       mEdges % BPF);
            checkOutput("byte_done",     int'(byte_done),     int'(mBd));
            checkOutput("frame_err",     int'(frame_err),     int'(mFe));
            if (sclk_pos_edge === 1'b1) cntSclkPos++;
            if (sclk_neg_edge === 1'b1) cntSclkNeg++;
            if (cs_fall === 1'b1)       cntCsFall++;
            if (cs_rise === 1'b1)       cntCsRise++;
            if (byte_done === 1'b1)     cntByteDone++;
            if (frame_err === 1'b1)     cntFrameErr++;
            if (frame_err === 1'b1 && cs_rise === 1'b1) cntErrOnRise++;
        end
    end

    // Literal check that every output sits at its reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, ".sclk_cond"}, int'(sclk_cond), 0);
        checkOutput({tag, ".cs_cond"},   int'(cs_cond),   1);
        checkOutput({tag, ".mosi_cond"}, int'(mosi_cond), 0);
        checkOutput({tag, ".bit_cnt"},   int'(bit_cnt),   0);
        checkOutput({tag, ".pulses"},
                    int'({sclk_pos_edge, sclk_neg_edge, cs_fall, cs_rise, byte_done, frame_err}), 0);
    endtask

    int   latency;
    int   base;
    logic bitVal;
    logic [7:0] pattern;

    initial begin
        // Reset held two cycles while the pins toggle.
        reset    = 1'b1;
        sclk_pin = 1'b1;
        cs_pin   = 1'b0;
        mosi_pin = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 1'b0, 1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1);
        checkResetState("reset");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkResetState("idle");

        // Clean sclk rise while cs is idle: six clocks to the pulse.
        base    = cntSclkPos;
        latency = -1;
        sclk_pin = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (sclk_pos_edge === 1'b1 && latency < 0) latency = k;
        end
        checkOutput("clean.latency", latency, 6);
        checkOutput("clean.pos_count", cntSclkPos - base, 1);
        checkOutput("clean.sclk_cond", int'(sclk_cond), 1);
        checkOutput("clean.no_neg", cntSclkNeg, 0);
        checkOutput("clean.bit_cnt_idle", int'(bit_cnt), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("clean.neg_count", cntSclkNeg, 1);

        // cs glitch of three cycles is dropped; four cycles passes.
        base = cntCsFall;
        applyStimulus(1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);
        checkOutput("glitch3.cs_fall", cntCsFall - base, 0);
        checkOutput("glitch3.cs_cond", int'(cs_cond), 1);
        base = cntCsRise;
        applyStimulus(1'b0, 1'b0, 1'b0, 4);
        applyStimulus(1'b0, 1'b1, 1'b0, 12);
        checkOutput("glitch4.cs_fall", cntCsFall, 1);
        checkOutput("glitch4.cs_rise", cntCsRise - base, 1);
        checkOutput("glitch4.frame_err", cntFrameErr, 0);

        // Full frame of eight bits, data 0xA5.
        pattern = 8'hA5;
        base = cntCsRise;
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        for (int b = 0; b < 8; b++) begin
            bitVal = pattern[7 - b];
            applyStimulus(1'b0, 1'b0, bitVal, 10);
            applyStimulus(1'b1, 1'b0, bitVal, 10);
            checkOutput("frame.bit_cnt", int'(bit_cnt), (b + 1) % 8);
            if (b == 6) checkOutput("frame.byte_done_early", cntByteDone, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 12);
        checkOutput("frame.byte_done", cntByteDone, 1);
        checkOutput("frame.cs_rise", cntCsRise - base, 1);
        checkOutput("frame.frame_err", cntFrameErr, 0);
        checkOutput("frame.bit_cnt_end", int'(bit_cnt), 0);

        // Aborted frame: five bits, then cs and sclk rise together.
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 10);
            applyStimulus(1'b1, 1'b0, 1'b1, 10);
        end
        checkOutput("abort.bit_cnt", int'(bit_cnt), 5);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b1, 1'b1, 1'b0, 12);
        checkOutput("abort.frame_err", cntFrameErr, 1);
        checkOutput("abort.err_on_rise", cntErrOnRise, 1);
        checkOutput("abort.byte_done", cntByteDone, 1);
        checkOutput("abort.bit_cnt_end", int'(bit_cnt), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 10);

        // Reset in the middle of a frame, then a fresh frame.
        base = cntCsFall;
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        for (int b = 0; b < 3; b++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 10);
            applyStimulus(1'b0, 1'b0, 1'b0, 10);
        end
        checkOutput("midreset.bit_cnt_before", int'(bit_cnt), 3);
        reset = 1'b1;
        @(negedge clk);
        checkResetState("midreset");
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 12);
        checkOutput("midreset.frame_err", cntFrameErr, 1);
        checkOutput("midreset.refall", cntCsFall - base, 2);
        checkOutput("midreset.bit_cnt_restart", int'(bit_cnt), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10);
        checkOutput("midreset.bit_cnt_one", int'(bit_cnt), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10);
        applyStimulus(1'b0, 1'b1, 1'b0, 12);
        checkOutput("midreset.final_err", cntFrameErr, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
